// File: rtl/miriscv_lsu.sv
// miriscv_lsu -- load-store unit of the miriscv core.
//
// Takes the decoder's memory request (ALU result as address, RD2 as store
// data) and performs it on the word-organised data bus. It produces byte
// enables and lane-replicated write data, sign/zero-extends load data and
// holds the core stalled until the access completes.
//
// Ports:
//   clk_i, rstn_i             core clock, synchronous active-low reset
//   lsu_req_i, lsu_we_i       access request, 1 = store / 0 = load
//   lsu_size_i                DATA_SIZE_* code
//   lsu_addr_i, lsu_data_i    byte address, store data
//   lsu_data_o                extended load result (registered)
//   lsu_stall_req_o           core must hold PC and request while high
//   lsu_misalign_o            one-cycle misaligned-access flag
//   data_req_o .. data_wdata_o  bus request side (word address, bits [1:0] = 0)
//   data_gnt_i, data_rvalid_i, data_rdata_i  bus grant / response
//
// Configuration macro: LSU_MISALIGN_EXC_EN. When defined, misaligned
// half/word accesses skip the bus and raise lsu_misalign_o for one cycle.
// When undefined, misaligned addresses are truncated and proceed normally.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] DATA_SIZE_BYTE   = 3'd0;
    localparam logic [2:0] DATA_SIZE_HALF   = 3'd1;
    localparam logic [2:0] DATA_SIZE_WORD   = 3'd2;
    localparam logic [2:0] DATA_SIZE_U_BYTE = 3'd4;
    localparam logic [2:0] DATA_SIZE_U_HALF = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsuState_t;

    lsuState_t   state;
    logic [2:0]  sizeReg;
    logic [1:0]  offsetReg;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [31:0] loadExt;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        misaligned;

    // Byte enables and lane replication for the incoming request.
    always_comb begin
        reqBe    = 4'b1111;
        reqWdata = lsu_data_i;
        case (lsu_size_i)
            DATA_SIZE_BYTE, DATA_SIZE_U_BYTE: begin
                reqBe    = 4'b0001 << lsu_addr_i[1:0];
                reqWdata = {4{lsu_data_i[7:0]}};
            end
            DATA_SIZE_HALF, DATA_SIZE_U_HALF: begin
                reqBe    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                reqWdata = {2{lsu_data_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_EXC_EN
    always_comb begin
        misaligned = 1'b0;
        case (lsu_size_i)
            DATA_SIZE_HALF, DATA_SIZE_U_HALF: misaligned = lsu_addr_i[0];
            DATA_SIZE_WORD:                   misaligned = |lsu_addr_i[1:0];
            default:                          misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Lane selection uses the offset latched at request time, not the live address.
    always_comb begin
        byteSel = data_rdata_i[{offsetReg, 3'b000} +: 8];
        halfSel = offsetReg[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (sizeReg)
            DATA_SIZE_BYTE:   loadExt = {{24{byteSel[7]}}, byteSel};
            DATA_SIZE_U_BYTE: loadExt = {24'd0, byteSel};
            DATA_SIZE_HALF:   loadExt = {{16{halfSel[15]}}, halfSel};
            DATA_SIZE_U_HALF: loadExt = {16'd0, halfSel};
            default:          loadExt = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            lsu_data_o     <= '0;
            lsu_misalign_o <= 1'b0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_be_o      <= '0;
            data_addr_o    <= '0;
            data_wdata_o   <= '0;
            sizeReg        <= '0;
            offsetReg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (misaligned) begin
                            lsu_misalign_o <= 1'b1;
                            state          <= DONE;
                        end else begin
                            data_req_o   <= 1'b1;
                            data_we_o    <= lsu_we_i;
                            data_be_o    <= reqBe;
                            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            data_wdata_o <= reqWdata;
                            sizeReg      <= lsu_size_i;
                            offsetReg    <= lsu_addr_i[1:0];
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        if (!data_we_o) begin
                            lsu_data_o <= loadExt;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    lsu_misalign_o <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu_stall_req_o = ((state == IDLE) && lsu_req_i) || (state == REQ) || (state == WAIT);

endmodule

// File: tb/tb_miriscv_lsu.sv
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_misalign_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] modelData = '0;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gntDly;
        int          rvDly;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        logic [31:0] expLd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access covers n bytes starting at the address rounded
    // down to a multiple of n; stores repeat the low n bytes of the data.
    function automatic int unsigned nBytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] refBe(input logic [2:0] s, input logic [31:0] a);
        int unsigned n  = nBytes(s);
        int unsigned st = (int'(a[1:0]) / n) * n;
        logic [3:0]  r;
        for (int unsigned k = 0; k < 4; k++) r[k] = (k >= st) && (k < st + n);
        return r;
    endfunction

    function automatic logic [31:0] refWd(input logic [2:0] s, input logic [31:0] d);
        int unsigned n = nBytes(s);
        logic [31:0] r;
        for (int unsigned k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] refLd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        int unsigned n  = nBytes(s);
        int unsigned st = (int'(a[1:0]) / n) * n;
        logic [31:0] v;
        if (n == 4) return rd;
        v = (rd >> (8 * st)) & ((32'd1 << (8 * n)) - 32'd1);
        if ((s == 3'd0 || s == 3'd1) && v >= (32'd1 << (8 * n - 1)))
            v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic bit refMis(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
        return ((s == 3'd1 || s == 3'd5) && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
`else
        return (s == 3'd7) && 1'b0 && (a == 32'd0);
`endif
    endfunction

    // One full access starting at a negedge with the LSU idle.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gDly, input int rDly,
                          input logic [3:0] expBe, input logic [31:0] expWd, input logic [31:0] expLd);
        logic [31:0] expOut;
        bit          mis;
        mis    = refMis(size, addr);
        expOut = (we || mis) ? modelData : expLd;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_addr_i = addr; lsu_data_i = wdata;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        #1 chk("stall_idle_req", 32'(lsu_stall_req_o), 32'd1);
        @(negedge clk_i);
        if (mis) begin
            chk("misalign_pulse", 32'(lsu_misalign_o), 32'd1);
            chk("misalign_no_req", 32'(data_req_o), 32'd0);
            chk("misalign_stall", 32'(lsu_stall_req_o), 32'd0);
            chk("misalign_data", lsu_data_o, modelData);
            lsu_req_i = 1'b0;
            @(negedge clk_i);
            chk("misalign_clear", 32'(lsu_misalign_o), 32'd0);
            return;
        end
        // Scramble the inputs the LSU must not latch once the request is held.
        lsu_we_i = ~we; lsu_addr_i = $urandom; lsu_data_i = $urandom; lsu_size_i = 3'($urandom_range(0, 7));
        for (int i = 0; i <= gDly; i++) begin
            chk("req_high", 32'(data_req_o), 32'd1);
            chk("req_we", 32'(data_we_o), 32'(we));
            chk("req_be", 32'(data_be_o), 32'(expBe));
            chk("req_addr", data_addr_o, {addr[31:2], 2'b00});
            chk("req_wdata", data_wdata_o, expWd);
            chk("req_stall", 32'(lsu_stall_req_o), 32'd1);
            data_gnt_i    = (i == gDly);
            data_rvalid_i = 1'($urandom_range(0, 1));
            data_rdata_i  = $urandom;
            @(negedge clk_i);
        end
        data_gnt_i = 1'b0;
        for (int j = 0; j <= rDly; j++) begin
            chk("wait_req_low", 32'(data_req_o), 32'd0);
            chk("wait_stall", 32'(lsu_stall_req_o), 32'd1);
            data_gnt_i    = 1'($urandom_range(0, 1));
            data_rvalid_i = (j == rDly);
            data_rdata_i  = (j == rDly) ? rdata : $urandom;
            @(negedge clk_i);
        end
        data_gnt_i = 1'b0;
        chk("done_stall", 32'(lsu_stall_req_o), 32'd0);
        chk("done_data", lsu_data_o, expOut);
        modelData = expOut;
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = $urandom;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("idle_hold", lsu_data_o, modelData);
        chk("idle_stall", 32'(lsu_stall_req_o), 32'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        tbl[1] = '{1'b0, 3'd5, 32'h0000_0202, 32'h0,         32'h8001_7FFF, 0, 0, 4'b1100, 32'h0,         32'h0000_8001};
        tbl[2] = '{1'b1, 3'd1, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0,         3, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        tbl[3] = '{1'b1, 3'd2, 32'h0000_0007, 32'h0BAD_F00D, 32'h0,         0, 0, 4'b1111, 32'h0BAD_F00D, 32'h0};
        tbl[4] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,         32'h1234_5678, 1, 2, 4'b1111, 32'h0,         32'h1234_5678};
        tbl[5] = '{1'b0, 3'd1, 32'h0000_001E, 32'h0,         32'h8765_4321, 0, 1, 4'b1100, 32'h0,         32'hFFFF_8765};
        tbl[6] = '{1'b0, 3'd4, 32'h0000_0005, 32'h0,         32'h0000_9A00, 2, 0, 4'b0010, 32'h0,         32'h0000_009A};
        tbl[7] = '{1'b1, 3'd0, 32'h0000_0002, 32'h1234_5655, 32'h0,         0, 0, 4'b0100, 32'h5555_5555, 32'h0};
        tbl[8] = '{1'b0, 3'd3, 32'h0000_0008, 32'h0,         32'hCAFE_BABE, 0, 0, 4'b1111, 32'h0,         32'hCAFE_BABE};
        tbl[9] = '{1'b0, 3'd1, 32'h0000_0100, 32'h0,         32'h0001_7FFF, 1, 1, 4'b0011, 32'h0,         32'h0000_7FFF};

        rstn_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = '0;
        lsu_addr_i = '0; lsu_data_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_data", lsu_data_o, 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_we", 32'(data_we_o), 32'd0);
        chk("rst_misalign", 32'(lsu_misalign_o), 32'd0);
        chk("rst_stall_lo", 32'(lsu_stall_req_o), 32'd0);
        lsu_req_i = 1'b1;
        #1 chk("rst_stall_follow", 32'(lsu_stall_req_o), 32'd1);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        rstn_i = 1'b1;
        @(negedge clk_i);

        for (int t = 0; t < 10; t++)
            access(tbl[t].we, tbl[t].size, tbl[t].addr, tbl[t].wdata, tbl[t].rdata,
                   tbl[t].gntDly, tbl[t].rvDly, tbl[t].expBe, tbl[t].expWd, tbl[t].expLd);

        for (int r = 0; r < 40; r++) begin
            logic        we;
            logic [2:0]  sz;
            logic [31:0] ad, wd, rd;
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            ad = $urandom; wd = $urandom; rd = $urandom;
            access(we, sz, ad, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                   refBe(sz, ad), refWd(sz, wd), refLd(sz, ad, rd));
        end

        // Reset while waiting for the response; the late rvalid must be dropped.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2;
        lsu_addr_i = 32'h20; lsu_data_i = '0;
        @(negedge clk_i);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        chk("rstw_in_wait", 32'(lsu_stall_req_o & ~data_req_o), 32'd1);
        rstn_i = 1'b0; lsu_req_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk("rstw_req", 32'(data_req_o), 32'd0);
        chk("rstw_data", lsu_data_o, 32'd0);
        chk("rstw_stall", 32'(lsu_stall_req_o), 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'hAAAA_AAAA;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("rstw_late_rvalid", lsu_data_o, 32'd0);
        chk("rstw_no_done", 32'(lsu_stall_req_o | data_req_o), 32'd0);
        modelData = '0;

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
